// File: rtl/cache_event_counter_bank.sv
// cache_event_counter_bank: event/wall-time counters with sticky overflow, atomic snapshot shadow and registered read port
module cache_event_counter_bank #(
  parameter int N_EVENTS = 9,
  parameter int CNT_W = 64,
  parameter logic [N_EVENTS-1:0] EDGE_MASK = '0,
  parameter bit SATURATE = 1'b0,
  parameter logic [31:0] CACHE_ID = 32'h0
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [N_EVENTS-1:0] event_i,
  input  logic [31:0]         comm_i,
  output logic [31:0]         comm_o,
  output logic                ovf_any_o,
  output logic                snap_done_o
);
  localparam int NC = N_EVENTS + 1;
  logic [NC-1:0][CNT_W-1:0] cnt_q, cnt_d, shd_q, shd_d, src_c;
  logic [NC-1:0] ovf_q, ovf_d, sov_q, sov_d, src_o, hit;
  logic [N_EVENTS-1:0] prev_q, prev_d;
  logic snap_q, snap_d, done_q, done_d;
  logic [31:0] comm_q, comm_d;
  logic [63:0] rd;
  logic [6:0] ch;
  logic en, clr, snap;
  assign ch = comm_i[7:1];
  assign clr = comm_i[25];
  assign en = comm_i[24] & ~clr;
  assign snap = comm_i[26] & ~snap_q;
  assign hit = {1'b1, event_i & ~(EDGE_MASK & prev_q)};
  assign src_c = comm_i[27] ? shd_q : cnt_q;
  assign src_o = comm_i[27] ? sov_q : ovf_q;
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      cnt_d[i] = clr ? '0 : en && hit[i] && !(SATURATE && &cnt_q[i]) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      ovf_d[i] = !clr && (ovf_q[i] || (en && hit[i] && &cnt_q[i]));
    end
    shd_d = snap ? cnt_q : shd_q;
    sov_d = snap ? ovf_q : sov_q;
    prev_d = event_i;
    snap_d = comm_i[26];
    done_d = snap;
  end
  always_comb begin
    rd = '0;
    for (int i = 0; i < NC; i++)
      if (7'(i) == ch) rd = 64'(src_c[i]);
    if (ch == 7'(NC)) rd = 64'(src_o);
    comm_d = ch == 7'h7f ? (comm_i[0] ? '0 : CACHE_ID) : comm_i[0] ? rd[63:32] : rd[31:0];
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      shd_q <= '0;
      ovf_q <= '0;
      sov_q <= '0;
      prev_q <= '0;
      snap_q <= 1'b0;
      done_q <= 1'b0;
      comm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      shd_q <= shd_d;
      ovf_q <= ovf_d;
      sov_q <= sov_d;
      prev_q <= prev_d;
      snap_q <= snap_d;
      done_q <= done_d;
      comm_q <= comm_d;
    end
  end
  assign comm_o = comm_q;
  assign ovf_any_o = |ovf_q;
  assign snap_done_o = done_q;
endmodule

// File: tb/tb_cache_event_counter_bank.sv
// tb_cache_event_counter_bank: random stimulus vs. array-based reference model, scoreboard queue checked by a monitor
module tb_cache_event_counter_bank;
  localparam int N = 9;
  localparam logic [N-1:0] EM_A = 9'h0A8;
  localparam logic [N-1:0] EM_B = 9'h155;
  localparam logic [31:0] ID_A = 32'hCAFE_0001;
  localparam logic [31:0] ID_B = 32'hCAFE_0002;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] ev;
  logic [31:0] comm;
  logic [31:0] co_a, co_b;
  logic oa, ob, sa, sb;
  always #5 clk = ~clk;
  cache_event_counter_bank #(.N_EVENTS(N), .CNT_W(4), .EDGE_MASK(EM_A), .SATURATE(1'b0), .CACHE_ID(ID_A)) dut_a (
    .clock_i(clk), .reset_i(rst), .event_i(ev), .comm_i(comm), .comm_o(co_a), .ovf_any_o(oa), .snap_done_o(sa));
  cache_event_counter_bank #(.N_EVENTS(N), .CNT_W(3), .EDGE_MASK(EM_B), .SATURATE(1'b1), .CACHE_ID(ID_B)) dut_b (
    .clock_i(clk), .reset_i(rst), .event_i(ev), .comm_i(comm), .comm_o(co_b), .ovf_any_o(ob), .snap_done_o(sb));
  typedef struct packed {
    logic [31:0] ca;
    logic [31:0] cb;
    logic oa;
    logic ob;
    logic s;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  longint unsigned cnt[2][N+1];
  longint unsigned sh[2][N+1];
  logic [N:0] ov[2];
  logic [N:0] shov[2];
  logic [N-1:0] prev;
  logic sprev;
  function automatic longint unsigned maxv(int k);
    return (64'd1 << (k == 0 ? 4 : 3)) - 1;
  endfunction
  function automatic logic [31:0] rd(int k, logic [31:0] c);
    int ch;
    longint unsigned v;
    ch = int'(c[7:1]);
    v = 0;
    if (ch == 127) return c[0] ? 32'h0 : (k == 0 ? ID_A : ID_B);
    if (ch <= N) v = c[27] ? sh[k][ch] : cnt[k][ch];
    else if (ch == N + 1) v = 64'(c[27] ? shov[k] : ov[k]);
    return c[0] ? v[63:32] : v[31:0];
  endfunction
  task automatic model_step();
    exp_t e;
    logic sedge;
    logic [N-1:0] em;
    logic h;
    e = '0;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i <= N; i++) begin
          cnt[k][i] = 0;
          sh[k][i] = 0;
        end
        ov[k] = '0;
        shov[k] = '0;
      end
      prev = '0;
      sprev = 1'b0;
    end else begin
      e.ca = rd(0, comm);
      e.cb = rd(1, comm);
      sedge = comm[26] && !sprev;
      for (int k = 0; k < 2; k++) begin
        em = k == 0 ? EM_A : EM_B;
        if (sedge) begin
          for (int i = 0; i <= N; i++) sh[k][i] = cnt[k][i];
          shov[k] = ov[k];
        end
        for (int i = 0; i <= N; i++) begin
          h = i == N ? 1'b1 : em[i] ? (ev[i] && !prev[i]) : ev[i];
          if (comm[25]) begin
            cnt[k][i] = 0;
            ov[k][i] = 1'b0;
          end else if (comm[24] && h) begin
            if (cnt[k][i] == maxv(k)) begin
              ov[k][i] = 1'b1;
              cnt[k][i] = k == 1 ? maxv(k) : 0;
            end else cnt[k][i] = cnt[k][i] + 1;
          end
        end
      end
      prev = ev;
      sprev = comm[26];
      e.oa = |ov[0];
      e.ob = |ov[1];
      e.s = sedge;
    end
    q.push_back(e);
  endtask
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("comm_o_a", co_a, e.ca);
        chk("comm_o_b", co_b, e.cb);
        chk("ovf_any_a", 32'(oa), 32'(e.oa));
        chk("ovf_any_b", 32'(ob), 32'(e.ob));
        chk("snap_done_a", 32'(sa), 32'(e.s));
        chk("snap_done_b", 32'(sb), 32'(e.s));
      end
    end
  end
  initial begin : stim
    logic snap_lvl;
    int r;
    int ch;
    logic [31:0] c;
    snap_lvl = 1'b0;
    rst = 1'b1;
    ev = '0;
    comm = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = cyc < 3 || $urandom_range(0, 399) == 0;
      ev = N'($urandom);
      r = $urandom_range(0, 15);
      ch = r < 12 ? $urandom_range(0, N + 1) : r < 14 ? 127 : $urandom_range(0, 127);
      if ($urandom_range(0, 7) == 0) snap_lvl = ~snap_lvl;
      c = $urandom;
      c[7:1] = 7'(ch);
      c[24] = $urandom_range(0, 9) != 0;
      c[25] = (cyc % 500) >= 490 || $urandom_range(0, 59) == 0;
      c[26] = snap_lvl;
      comm = c;
      model_step();
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
